// File: rtl/nested_int_ctrl.sv
// Vectored, nesting interrupt controller: edge-latched requests, priority select,
// EPC stack for pre-emption, and PC substitution between next-PC mux and PC register.
module nested_int_ctrl #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned NEST_DEPTH = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0008,
    localparam int unsigned ID_W      = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1,
    localparam int unsigned DW        = $clog2(NEST_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            int_clr,
    input  logic [N_CH-1:0] irq,
    input  logic [31:0]     pc_next,
    input  logic            eret,
    input  logic            stall,
    input  logic            mask_we,
    input  logic [N_CH-1:0] mask_wdata,
    output logic [31:0]     pc,
    output logic            intr,
    output logic [ID_W-1:0] int_id,
    output logic            int_active,
    output logic [DW-1:0]   depth,
    output logic [N_CH-1:0] pending,
    output logic            eret_err
);

    // Level width must hold N_CH, which encodes "idle" (no handler running).
    localparam int unsigned LW = $clog2(N_CH + 1);

    logic [N_CH-1:0] s1_q, s2_q, s3_q;
    logic [N_CH-1:0] pend_q, pend_d, mask_q;
    logic [N_CH-1:0] rise, elig, acc_mask;
    logic [LW-1:0]   lvl_q, lvl_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [31:0]     epc_q  [NEST_DEPTH];
    logic [LW-1:0]   elvl_q [NEST_DEPTH];
    logic            eret_err_q;
    logic            take, pop;
    logic [ID_W-1:0] id;
    logic [31:0]     top_pc;
    logic [LW-1:0]   top_lvl;

    always_comb begin
        rise = s2_q & ~s3_q;
        elig = '0;
        for (int unsigned i = 0; i < N_CH; i++)
            elig[i] = pend_q[i] & mask_q[i] & (LW'(i) < lvl_q);

        // Scan from the lowest priority upward so the lowest index wins.
        id = '0;
        for (int unsigned k = 0; k < N_CH; k++)
            if (elig[N_CH-1-k]) id = ID_W'(N_CH-1-k);

        pop  = eret & (depth_q != '0);
        take = (|elig) & ~stall & ~eret & (depth_q < DW'(NEST_DEPTH));

        top_pc  = '0;
        top_lvl = '0;
        for (int unsigned k = 0; k < NEST_DEPTH; k++) begin
            if (DW'(k) == depth_q - DW'(1)) begin
                top_pc  = epc_q[k];
                top_lvl = elvl_q[k];
            end
        end

        acc_mask = '0;
        for (int unsigned i = 0; i < N_CH; i++)
            acc_mask[i] = take & (ID_W'(i) == id);
        // A new rising edge on the same edge as acceptance re-pends the channel.
        pend_d = (pend_q & ~acc_mask) | rise;

        lvl_d   = lvl_q;
        depth_d = depth_q;
        if (take) begin
            lvl_d   = LW'(id);
            depth_d = depth_q + DW'(1);
        end else if (pop) begin
            lvl_d   = top_lvl;
            depth_d = depth_q - DW'(1);
        end

        if (int_clr)   pc = '0;
        else if (pop)  pc = top_pc;
        else if (take) pc = VEC_BASE + 32'(id) * VEC_STRIDE;
        else           pc = pc_next;
    end

    always_ff @(posedge clk or posedge int_clr) begin
        if (int_clr) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            pend_q     <= '0;
            mask_q     <= '1;
            lvl_q      <= LW'(N_CH);
            depth_q    <= '0;
            eret_err_q <= 1'b0;
            for (int unsigned k = 0; k < NEST_DEPTH; k++) begin
                epc_q[k]  <= '0;
                elvl_q[k] <= '0;
            end
        end else begin
            s1_q    <= irq;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            lvl_q   <= lvl_d;
            depth_q <= depth_d;
            if (mask_we)                  mask_q     <= mask_wdata;
            if (eret && depth_q == '0)    eret_err_q <= 1'b1;
            for (int unsigned k = 0; k < NEST_DEPTH; k++) begin
                if (take && DW'(k) == depth_q) begin
                    epc_q[k]  <= pc_next;
                    elvl_q[k] <= lvl_q;
                end
            end
        end
    end

    assign intr       = take;
    assign int_id     = id;
    assign int_active = (depth_q != '0);
    assign depth      = depth_q;
    assign pending    = pend_q;
    assign eret_err   = eret_err_q;

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Directed bench for nested_int_ctrl: default instance plus a 2-deep stack instance
// sharing the same stimulus; expectations are hand-computed vectors/return PCs.
module tb_nested_int_ctrl;

    logic        clk = 1'b0;
    logic        int_clr;
    logic [3:0]  irq;
    logic [31:0] pc_next;
    logic        eret, stall, mask_we;
    logic [3:0]  mask_wdata;

    logic [31:0] pc0, pc1;
    logic        intr0, intr1, act0, act1, err0, err1;
    logic [1:0]  id0, id1;
    logic [2:0]  dep0;
    logic [1:0]  dep1;
    logic [3:0]  pend0, pend1;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc;

    always #5 clk = ~clk;

    nested_int_ctrl u0 (
        .clk(clk), .int_clr(int_clr), .irq(irq), .pc_next(pc_next), .eret(eret),
        .stall(stall), .mask_we(mask_we), .mask_wdata(mask_wdata), .pc(pc0),
        .intr(intr0), .int_id(id0), .int_active(act0), .depth(dep0),
        .pending(pend0), .eret_err(err0)
    );

    nested_int_ctrl #(.NEST_DEPTH(2)) u1 (
        .clk(clk), .int_clr(int_clr), .irq(irq), .pc_next(pc_next), .eret(eret),
        .stall(stall), .mask_we(mask_we), .mask_wdata(mask_wdata), .pc(pc1),
        .intr(intr1), .int_id(id1), .int_active(act1), .depth(dep1),
        .pending(pend1), .eret_err(err1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse one line and stop right after E2, when the request has just pended.
    task automatic pulse_wait(input int unsigned ch);
        irq[ch] = 1'b1;
        cyc();
        irq[ch] = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic do_reset();
        int_clr = 1'b1;
        cyc();
        int_clr = 1'b0;
        cyc();
    endtask

    initial begin
        int_clr = 1'b1; irq = '0; pc_next = 32'h55; eret = 1'b0;
        stall = 1'b0; mask_we = 1'b0; mask_wdata = '0;
        #2;
        check("rst_pc", pc0, 32'h0);
        check("rst_intr", intr0, 0);
        check("rst_active", act0, 0);
        check("rst_pending", pend0, 0);
        check("rst_depth", dep0, 0);
        check("rst_err", err0, 0);
        cyc();
        int_clr = 1'b0;
        cyc();

        // Single request on ch2
        pc_next = 32'h100;
        irq[2] = 1'b1;
        cyc();
        irq[2] = 1'b0;
        cyc();
        check("lat_e1_pend", pend0, 0);
        check("lat_e1_intr", intr0, 0);
        cyc();
        check("single_pend", pend0, 4'b0100);
        check("single_intr", intr0, 1);
        check("single_id", id0, 2);
        check("single_pc", pc0, 32'h14);
        cyc();
        check("single_depth", dep0, 1);
        check("single_active", act0, 1);
        check("single_pclr", pend0, 0);
        check("single_pc_pass", pc0, 32'h100);
        pc_next = 32'h180; eret = 1'b1; #1;
        check("single_eret_pc", pc0, 32'h100);
        cyc();
        eret = 1'b0; #1;
        check("single_eret_depth", dep0, 0);
        check("single_no_err", err0, 0);

        // Priority and nesting
        pc_next = 32'h200;
        pulse_wait(3);
        check("nest3_intr", intr0, 1);
        check("nest3_id", id0, 3);
        check("nest3_pc", pc0, 32'h1C);
        cyc();
        pc_next = 32'h300;
        pulse_wait(1);
        check("nest1_intr", intr0, 1);
        check("nest1_id", id0, 1);
        check("nest1_pc", pc0, 32'h0C);
        cyc();
        check("nest_depth2", dep0, 2);
        pulse_wait(3);
        check("nest_low_pend", pend0, 4'b1000);
        check("nest_low_blocked", intr0, 0);
        eret = 1'b1; #1;
        check("nest_eret1_pc", pc0, 32'h300);
        cyc();
        check("nest_eret1_depth", dep0, 1);
        check("nest_eret2_pc", pc0, 32'h200);
        check("nest_eret2_intr", intr0, 0);
        cyc();
        eret = 1'b0; #1;
        check("nest_after_depth", dep0, 0);
        check("nest_reissue_intr", intr0, 1);
        check("nest_reissue_pc", pc0, 32'h1C);
        cyc();
        eret = 1'b1;
        cyc();
        eret = 1'b0;

        // Mask
        mask_we = 1'b1; mask_wdata = 4'b1110;
        cyc();
        mask_we = 1'b0;
        pc_next = 32'h400;
        pulse_wait(0);
        check("mask_pend", pend0, 4'b0001);
        check("mask_intr", intr0, 0);
        cyc();
        check("mask_still", intr0, 0);
        mask_we = 1'b1; mask_wdata = 4'b1111;
        cyc();
        mask_we = 1'b0; #1;
        check("unmask_intr", intr0, 1);
        check("unmask_pc", pc0, 32'h04);
        cyc();
        eret = 1'b1;
        cyc();
        eret = 1'b0;

        // Stall, then eret coinciding with an eligible request
        pc_next = 32'h500;
        pulse_wait(3);
        cyc();
        check("coin_depth1", dep0, 1);
        stall = 1'b1;
        pulse_wait(2);
        check("stall_pend", pend0, 4'b0100);
        check("stall_intr", intr0, 0);
        cyc(); cyc(); cyc();
        check("stall_hold_intr", intr0, 0);
        check("stall_hold_pend", pend0, 4'b0100);
        stall = 1'b0; eret = 1'b1; pc_next = 32'h600; #1;
        check("coin_intr", intr0, 0);
        check("coin_pc", pc0, 32'h500);
        cyc();
        eret = 1'b0; #1;
        check("coin_depth0", dep0, 0);
        check("coin_next_intr", intr0, 1);
        check("coin_next_id", id0, 2);
        check("coin_next_pc", pc0, 32'h14);
        cyc();
        eret = 1'b1;
        cyc();
        eret = 1'b0;

        // eret at depth 0
        pc_next = 32'h700; eret = 1'b1; #1;
        check("eret0_pc", pc0, 32'h700);
        cyc();
        eret = 1'b0;
        check("eret0_err", err0, 1);
        check("eret0_depth", dep0, 0);
        cyc();
        check("eret0_sticky", err0, 1);

        // int_clr mid-handler
        pulse_wait(1);
        cyc();
        pulse_wait(3);
        check("clr_pre_depth", dep0, 1);
        check("clr_pre_pend", pend0, 4'b1000);
        int_clr = 1'b1; #1;
        check("clr_depth", dep0, 0);
        check("clr_pend", pend0, 0);
        check("clr_pc", pc0, 32'h0);
        check("clr_err", err0, 0);
        cyc();
        int_clr = 1'b0;
        cyc();

        // Level held high: one acceptance only, even with handler returning
        n_acc = 0;
        irq[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            eret = act0;
            #1;
            if (intr0) n_acc++;
        end
        irq[0] = 1'b0; eret = 1'b0;
        check("level_once", n_acc, 1);
        check("level_depth", dep0, 0);
        check("level_pend", pend0, 0);

        // Stack full on the 2-deep instance
        do_reset();
        pc_next = 32'h800;
        pulse_wait(3);
        cyc();
        pc_next = 32'h900;
        pulse_wait(2);
        check("full_ch2_intr", intr1, 1);
        cyc();
        check("full_depth", dep1, 2);
        pulse_wait(1);
        check("full_pend", pend1, 4'b0010);
        check("full_intr", intr1, 0);
        cyc(); cyc();
        check("full_hold_intr", intr1, 0);
        eret = 1'b1; #1;
        check("full_eret_pc", pc1, 32'h900);
        cyc();
        eret = 1'b0; #1;
        check("full_free_depth", dep1, 1);
        check("full_free_intr", intr1, 1);
        check("full_free_id", id1, 1);
        check("full_free_pc", pc1, 32'h0C);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nested_int_ctrl.md
# nested_int_ctrl

Parametrised, vectored, nesting interrupt controller for the 5-stage pipeline CPU, sitting between the fetch-stage next-PC mux and the program counter register. It latches rising edges on N_CH asynchronous interrupt lines and selects the highest-priority eligible request. On acceptance it substitutes a per-channel vector for the next PC. It saves return PCs on a NEST_DEPTH-entry EPC stack so a higher-priority request can pre-empt a running handler, and it restores the saved PC on eret.

## Interface
- N_CH, 4: number of interrupt channels (2..16); channel 0 has the highest priority.
- NEST_DEPTH, 4: EPC stack entries, which is the maximum nesting level (1..8).
- VEC_BASE, 32'h00000004: vector address of channel 0.
- VEC_STRIDE, 32'h00000008: address distance between consecutive channel vectors.
- Localparams: ID_W = max(1, clog2(N_CH)); DW = clog2(NEST_DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- int_clr  in  1  reset, asynchronous, active-high.
- irq  in  N_CH  asynchronous interrupt sources, rising-edge sensitive.
- pc_next  in  32  sequential/branch next PC from the pipeline.
- eret  in  1  return-from-interrupt decoded this cycle.
- stall  in  1  pipeline hold; no interrupt may be accepted while high.
- mask_we  in  1  write strobe for the enable mask.
- mask_wdata  in  N_CH  new mask value (1 = channel enabled).
- pc  out  32  PC to load (combinational).
- intr  out  1  interrupt accepted this cycle (combinational).
- int_id  out  ID_W  id of the accepted channel; valid when intr is high.
- int_active  out  1  nesting depth > 0.
- depth  out  DW  current nesting depth.
- pending  out  N_CH  latched pending requests.
- eret_err  out  1  sticky flag: eret was seen while depth == 0.

## Operation
- Synchronizer: each irq bit passes through two flops (s1, s2) and a history flop s3. A rising edge is rise = s2 & ~s3.
- Pending: pend[i] sets on rise[i] and clears when channel i is accepted. If a set and a clear hit the same bit on the same edge, the set wins.
- Mask: mask resets to all ones and loads mask_wdata on mask_we. A masked channel still latches pending but is not eligible.
- Current level cur_lvl: reset value N_CH, meaning idle. Channel i is eligible if pend[i] & mask[i] & (i < cur_lvl).
- Accept condition: take = any eligible & ~stall & ~eret & (depth < NEST_DEPTH). int_id is the lowest eligible index.
- On take (at the clock edge):
  - push {pc_next, cur_lvl} onto the stack;
  - cur_lvl <= int_id; pend[int_id] <= 0; depth++.
- On eret with depth > 0: pop the stack, restore cur_lvl, depth--.
- On eret with depth == 0: no pop, pc = pc_next, and eret_err sets. eret_err stays set until int_clr.
- A full stack blocks all acceptance; requests stay pending.
- pc selection, in priority order:
  1. int_clr: 32'h0.
  2. eret & depth > 0: top-of-stack EPC.
  3. take: VEC_BASE + int_id*VEC_STRIDE, 32-bit with wrap-around.
  4. Otherwise: pc_next.
- Simultaneous eret and an eligible request: the eret pops first. The request is re-evaluated next cycle against the restored cur_lvl.

## Timing
- Reset values: all flops 0; pend 0; depth 0; cur_lvl N_CH; mask all ones; eret_err 0. Outputs: pc 0, intr 0, int_active 0, pending 0.
- int_clr asserted mid-handler discards the stack and all pending requests immediately.
- Latency: irq rising, first sampled at edge E0 → s2 high at E1 → pend set at E2. intr is asserted in the cycle after E2 if the channel is eligible and stall is low.
- intr and pc are combinational within the accepting cycle. State (stack, cur_lvl, depth) updates at the following edge.
- A level held high produces only one request; the line must fall and rise again to re-pend.
- stall held high delays acceptance indefinitely without losing requests.

## Test plan
- Single request: N_CH=4, pulse irq[2] with pc_next=0x100. Required: intr=1, int_id=2, pc=0x14 in the cycle after E2. A later eret gives pc=0x100, depth 1→0.
- Priority and nesting: pend ch3 and accept it (pc_next=0x200). Raise irq[1] (pc_next=0x300): accepted, depth=2, pc=0x0C. Raise irq[3] again: not accepted while cur_lvl=1. Two erets return 0x300 then 0x200; the ch3 request is accepted after the second eret.
- Mask: write mask=4'b1110 and pulse irq[0]. Required: pending[0]=1, intr=0. Write mask=4'b1111: accepted, pc=0x04.
- Stack full: NEST_DEPTH=2 with nested ch3 then ch2. Pulse irq[1]: pending held and intr=0 until one eret frees an entry.
- Boundary cases:
  - eret at depth 0: pc=pc_next and eret_err=1.
  - eret coinciding with an eligible request: pop only, vector issued the next cycle.
  - stall=1 blocks acceptance.
  - int_clr mid-handler: depth=0, pending=0, pc=0.
- Edge-only behaviour: hold irq[0] high for 20 cycles. Required: exactly one acceptance.
